// File: rtl/jtag_param_tap_controller_pkg.sv
// Shared JTAG definitions: TAP state encoding, instruction opcodes,
// data-register select, capture/IDCODE defaults and the TAP next-state function.
package JtagGlobalPkg;

  typedef enum logic [3:0] {
    jtagExit2DrState     = 4'h0,
    jtagExit1DrState     = 4'h1,
    jtagShiftDrState     = 4'h2,
    jtagPauseDrState     = 4'h3,
    jtagSelectIrScanState = 4'h4,
    jtagUpdateDrState    = 4'h5,
    jtagCaptureDrState   = 4'h6,
    jtagSelectDrScanState = 4'h7,
    jtagExit2IrState     = 4'h8,
    jtagExit1IrState     = 4'h9,
    jtagShiftIrState     = 4'hA,
    jtagPauseIrState     = 4'hB,
    jtagIdleState        = 4'hC,
    jtagUpdateIrState    = 4'hD,
    jtagCaptureIrState   = 4'hE,
    jtagResetState       = 4'hF
  } JtagTapStates;

  typedef enum logic [4:0] {
    bypassRegister       = 5'b00000,
    userDefinedRegister  = 5'b00001,
    idcodeRegister       = 5'b00010,
    boundaryScanRegister = 5'b00110
  } JtagInstructionOpcodeEnum;

  typedef enum logic [1:0] {
    drBypass,
    drUser,
    drBsr,
    drIdcode
  } JtagDrSelect;

  localparam logic [4:0]  JTAG_IR_CAPTURE_DEFAULT = 5'b00001;
  localparam logic [31:0] JTAG_IDCODE_DEFAULT     = 32'h1000_0001;

  function automatic JtagTapStates jtagNextState(input JtagTapStates s, input logic tms);
    jtagNextState = jtagResetState;
    unique case (s)
      jtagResetState:        jtagNextState = tms ? jtagResetState        : jtagIdleState;
      jtagIdleState:         jtagNextState = tms ? jtagSelectDrScanState : jtagIdleState;
      jtagSelectDrScanState: jtagNextState = tms ? jtagSelectIrScanState : jtagCaptureDrState;
      jtagCaptureDrState:    jtagNextState = tms ? jtagExit1DrState      : jtagShiftDrState;
      jtagShiftDrState:      jtagNextState = tms ? jtagExit1DrState      : jtagShiftDrState;
      jtagExit1DrState:      jtagNextState = tms ? jtagUpdateDrState     : jtagPauseDrState;
      jtagPauseDrState:      jtagNextState = tms ? jtagExit2DrState      : jtagPauseDrState;
      jtagExit2DrState:      jtagNextState = tms ? jtagUpdateDrState     : jtagShiftDrState;
      jtagUpdateDrState:     jtagNextState = tms ? jtagSelectDrScanState : jtagIdleState;
      jtagSelectIrScanState: jtagNextState = tms ? jtagResetState        : jtagCaptureIrState;
      jtagCaptureIrState:    jtagNextState = tms ? jtagExit1IrState      : jtagShiftIrState;
      jtagShiftIrState:      jtagNextState = tms ? jtagExit1IrState      : jtagShiftIrState;
      jtagExit1IrState:      jtagNextState = tms ? jtagUpdateIrState     : jtagPauseIrState;
      jtagPauseIrState:      jtagNextState = tms ? jtagExit2IrState      : jtagPauseIrState;
      jtagExit2IrState:      jtagNextState = tms ? jtagUpdateIrState     : jtagShiftIrState;
      jtagUpdateIrState:     jtagNextState = tms ? jtagSelectDrScanState : jtagIdleState;
    endcase
  endfunction

endpackage

// File: rtl/jtag_param_tap_controller_if.sv
// Serial JTAG pin bundle between the master agent and the TAP target.
interface jtag_param_tap_controller_if;
  logic tms;
  logic tdi;
  logic tdo;
  logic tdoEnable;

  modport master (output tms, output tdi, input tdo, input tdoEnable);
  modport slave  (input tms, input tdi, output tdo, output tdoEnable);
endinterface

// File: rtl/jtag_param_tap_controller_tap_state_fsm.sv
// 16-state TAP controller: state register advanced by tms on each rising clk.
module jtag_tap_state_fsm
  import JtagGlobalPkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         tms,
  output JtagTapStates tapState
);

  // State register; async reset lands in Test-Logic-Reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) tapState <= jtagResetState;
    else       tapState <= jtagNextState(tapState, tms);
  end

endmodule

// File: rtl/jtag_param_tap_controller.sv
// Parametrised IEEE-1149.1-style TAP target: instruction register plus
// bypass, user-defined and boundary-scan data registers.
// Optional build macro JTAG_IDCODE_EN adds a 32-bit IDCODE register and makes
// IDCODE the reset instruction.
module jtag_param_tap_controller
  import JtagGlobalPkg::*;
#(
  parameter int unsigned         IR_WIDTH      = 5,
  parameter int unsigned         USER_DR_WIDTH = 32,
  parameter int unsigned         BSR_WIDTH     = 62,
  parameter logic [IR_WIDTH-1:0] IR_CAPTURE    = IR_WIDTH'(JTAG_IR_CAPTURE_DEFAULT)
`ifdef JTAG_IDCODE_EN
  , parameter logic [31:0]       IDCODE_VALUE  = JTAG_IDCODE_DEFAULT
`endif
) (
  input  logic                       clk,
  input  logic                       reset,
  jtag_param_tap_controller_if.slave jtag,
  output JtagTapStates               tapState,
  output logic [IR_WIDTH-1:0]        irValue,
  input  logic [BSR_WIDTH-1:0]       bsrIn,
  output logic [BSR_WIDTH-1:0]       bsrOut,
  output logic [USER_DR_WIDTH-1:0]   userDrOut,
  output logic                       updateDrPulse
);

  localparam logic [IR_WIDTH-1:0] OP_BYPASS = IR_WIDTH'(bypassRegister);
  localparam logic [IR_WIDTH-1:0] OP_USER   = IR_WIDTH'(userDefinedRegister);
  localparam logic [IR_WIDTH-1:0] OP_BSR    = IR_WIDTH'(boundaryScanRegister);
`ifdef JTAG_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] OP_IDCODE = IR_WIDTH'(idcodeRegister);
  localparam logic [IR_WIDTH-1:0] RESET_IR  = OP_IDCODE;
`else
  localparam logic [IR_WIDTH-1:0] RESET_IR  = OP_BYPASS;
`endif

  logic [IR_WIDTH-1:0]      irShift;
  logic                     bypassShift;
  logic [USER_DR_WIDTH-1:0] userShift;
  logic [BSR_WIDTH-1:0]     bsrShift;
`ifdef JTAG_IDCODE_EN
  logic [31:0]              idShift;
`endif
  logic                     tdoReg;
  logic                     tdoEnReg;
  logic                     enteringReset;
  JtagDrSelect              drSel;

  jtag_tap_state_fsm tapFsm (
    .clk      (clk),
    .reset    (reset),
    .tms      (jtag.tms),
    .tapState (tapState)
  );

  assign jtag.tdo       = tdoReg;
  assign jtag.tdoEnable = tdoEnReg;

  // Test-Logic-Reset is only reachable from SelectIrScan or itself with tms=1;
  // loading the reset instruction on that edge keeps irValue in step with tapState.
  assign enteringReset = jtag.tms &&
                         ((tapState == jtagSelectIrScanState) || (tapState == jtagResetState));

  // Instruction decode; unknown opcodes fall back to bypass.
  always_comb begin
    drSel = drBypass;
    if (irValue == OP_USER)     drSel = drUser;
    else if (irValue == OP_BSR) drSel = drBsr;
`ifdef JTAG_IDCODE_EN
    else if (irValue == OP_IDCODE) drSel = drIdcode;
`endif
  end

  // IR/DR capture, shift and update datapath plus registered tdo/tdoEnable/pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irValue       <= RESET_IR;
      irShift       <= '0;
      bypassShift   <= 1'b0;
      userShift     <= '0;
      bsrShift      <= '0;
`ifdef JTAG_IDCODE_EN
      idShift       <= '0;
`endif
      userDrOut     <= '0;
      bsrOut        <= '0;
      tdoReg        <= 1'b0;
      tdoEnReg      <= 1'b0;
      updateDrPulse <= 1'b0;
    end else begin
      tdoEnReg      <= 1'b0;
      updateDrPulse <= 1'b0;
      case (tapState)
        jtagCaptureIrState: irShift <= IR_CAPTURE;
        jtagShiftIrState: begin
          tdoReg   <= irShift[0];
          irShift  <= {jtag.tdi, irShift[IR_WIDTH-1:1]};
          tdoEnReg <= 1'b1;
        end
        jtagUpdateIrState: irValue <= irShift;
        jtagCaptureDrState: begin
          case (drSel)
            drUser: userShift <= userDrOut;
            drBsr:  bsrShift  <= bsrIn;
`ifdef JTAG_IDCODE_EN
            drIdcode: idShift <= IDCODE_VALUE;
`endif
            default: bypassShift <= 1'b0;
          endcase
        end
        jtagShiftDrState: begin
          tdoEnReg <= 1'b1;
          case (drSel)
            drUser: begin
              tdoReg    <= userShift[0];
              userShift <= {jtag.tdi, userShift[USER_DR_WIDTH-1:1]};
            end
            drBsr: begin
              tdoReg   <= bsrShift[0];
              // Shift-and-or form stays legal when BSR_WIDTH is 1.
              bsrShift <= (bsrShift >> 1) | (BSR_WIDTH'(jtag.tdi) << (BSR_WIDTH - 1));
            end
`ifdef JTAG_IDCODE_EN
            drIdcode: begin
              tdoReg  <= idShift[0];
              idShift <= {jtag.tdi, idShift[31:1]};
            end
`endif
            default: begin
              tdoReg      <= bypassShift;
              bypassShift <= jtag.tdi;
            end
          endcase
        end
        jtagUpdateDrState: begin
          updateDrPulse <= 1'b1;
          case (drSel)
            drUser:  userDrOut <= userShift;
            drBsr:   bsrOut    <= bsrShift;
            default: ;
          endcase
        end
        default: ;
      endcase
      if (enteringReset) irValue <= RESET_IR;
    end
  end

endmodule

// File: tb/tb_jtag_param_tap_controller.sv
// Directed scoreboard bench for jtag_param_tap_controller (default parameters).
module tb_jtag_param_tap_controller;
  import JtagGlobalPkg::*;

`ifdef JTAG_IDCODE_EN
  localparam logic [4:0] RESET_IR = 5'b00010;
`else
  localparam logic [4:0] RESET_IR = 5'b00000;
`endif

  logic         clk = 1'b0;
  logic         reset;
  JtagTapStates tapState;
  logic [4:0]   irValue;
  logic [61:0]  bsrIn;
  logic [61:0]  bsrOut;
  logic [31:0]  userDrOut;
  logic         updateDrPulse;

  int nCompared   = 0;
  int nMismatched = 0;
  logic expQ[$];

  logic [63:0] bsrCap = 64'h2AAA_AAAA_AAAA_AAAA;
  logic [63:0] bsrPat = 64'h0357_9BDF_2468_ACE1;
  logic [4:0]  irCap  = 5'b00001;

  jtag_param_tap_controller_if jtag ();

  jtag_param_tap_controller dut (
    .clk           (clk),
    .reset         (reset),
    .jtag          (jtag),
    .tapState      (tapState),
    .irValue       (irValue),
    .bsrIn         (bsrIn),
    .bsrOut        (bsrOut),
    .userDrOut     (userDrOut),
    .updateDrPulse (updateDrPulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nCompared++;
    assert (obs === exp) else begin
      nMismatched++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic popChk(input string tag);
    logic e;
    if (expQ.size() == 0) begin
      nCompared++;
      nMismatched++;
      $error("FAIL %s: observed tdo=%0b with no expected entry queued", tag, jtag.tdo);
    end else begin
      e = expQ.pop_front();
      chk(tag, 64'(jtag.tdo), 64'(e));
    end
  endtask

  task automatic step(input logic t, input logic d);
    jtag.tms = t;
    jtag.tdi = d;
    @(posedge clk);
    #1;
  endtask

  // From Idle: shift an opcode into the IR and return to Idle.
  task automatic loadIr(input logic [4:0] op);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      expQ.push_back(irCap[i]);
      step(i == 4, op[i]);
      popChk("irTdo");
      chk("irTdoEnable", 64'(jtag.tdoEnable), 64'd1);
    end
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    chk("irValue", 64'(irValue), 64'(op));
  endtask

  // From Idle: n-bit DR scan, optional pause after bit pauseAt, then update.
  task automatic scanDr(input logic [63:0] din, input int n, input logic [63:0] dexp,
                        input int pauseAt);
    logic brk;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      brk = (i == n - 1) || (i == pauseAt - 1);
      expQ.push_back(dexp[i]);
      step(brk, din[i]);
      popChk("drTdo");
      chk("drTdoEnable", 64'(jtag.tdoEnable), 64'd1);
      if (pauseAt > 0 && i == pauseAt - 1 && i != n - 1) begin
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("pauseHold", 64'(tapState), 64'(jtagPauseDrState));
        chk("pauseTdoEnable", 64'(jtag.tdoEnable), 64'd0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        chk("resumeShift", 64'(tapState), 64'(jtagShiftDrState));
      end
    end
    step(1'b1, 1'b0);
    chk("pulseBefore", 64'(updateDrPulse), 64'd0);
    step(1'b0, 1'b0);
    chk("pulseHigh", 64'(updateDrPulse), 64'd1);
    step(1'b0, 1'b0);
    chk("pulseAfter", 64'(updateDrPulse), 64'd0);
  endtask

  initial begin
    #100000;
    nMismatched++;
    $error("FAIL watchdog: observed no finish expected finish before 100000");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset    = 1'b1;
    jtag.tms = 1'b1;
    jtag.tdi = 1'b0;
    bsrIn    = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rstState", 64'(tapState), 64'(jtagResetState));
    chk("rstIr", 64'(irValue), 64'(RESET_IR));
    chk("rstTdo", 64'(jtag.tdo), 64'd0);
    chk("rstTdoEn", 64'(jtag.tdoEnable), 64'd0);
    chk("rstPulse", 64'(updateDrPulse), 64'd0);
    chk("rstUser", 64'(userDrOut), 64'd0);
    chk("rstBsr", 64'(bsrOut), 64'd0);
    reset = 1'b0;
    step(1'b0, 1'b0);
    chk("toIdle", 64'(tapState), 64'(jtagIdleState));

    loadIr(5'b00001);

    // Five tms=1 edges from ShiftDr reach reset and restore the reset instruction.
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    chk("inShiftDr", 64'(tapState), 64'(jtagShiftDrState));
    repeat (5) step(1'b1, 1'b0);
    chk("tmsResetState", 64'(tapState), 64'(jtagResetState));
    chk("tmsResetIr", 64'(irValue), 64'(RESET_IR));
    step(1'b0, 1'b0);

    loadIr(5'b00001);
    scanDr(64'hA5A5_3C3C, 32, 64'h0, 0);
    chk("userOut1", 64'(userDrOut), 64'hA5A5_3C3C);

    // FSM reset leaves update registers alone.
    repeat (5) step(1'b1, 1'b0);
    chk("fsmRstKeepsUser", 64'(userDrOut), 64'hA5A5_3C3C);
    chk("fsmRstIr", 64'(irValue), 64'(RESET_IR));
    step(1'b0, 1'b0);

    loadIr(5'b00001);
    scanDr(64'h0, 32, 64'hA5A5_3C3C, 0);
    chk("userOut2", 64'(userDrOut), 64'h0);

    // Async reset in the middle of a USER scan.
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
    chk("midScanTdoEn", 64'(jtag.tdoEnable), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("midRstState", 64'(tapState), 64'(jtagResetState));
    chk("midRstTdoEn", 64'(jtag.tdoEnable), 64'd0);
    chk("midRstUser", 64'(userDrOut), 64'h0);
    chk("midRstIr", 64'(irValue), 64'(RESET_IR));
    @(posedge clk);
    #1 reset = 1'b0;
    step(1'b0, 1'b0);
    chk("postRstIdle", 64'(tapState), 64'(jtagIdleState));

    // Boundary scan: capture bsrIn, shift a new pattern in.
    bsrIn = bsrCap[61:0];
    loadIr(5'b00110);
    scanDr(bsrPat, 62, bsrCap, 0);
    chk("bsrOut", 64'(bsrOut), bsrPat);
    chk("bsrKeepsUser", 64'(userDrOut), 64'h0);

    // Undefined opcode behaves as 1-bit bypass: in 1,0,1,1 -> out 0,1,0,1.
    loadIr(5'b10101);
    scanDr(64'hD, 4, 64'hA, 0);
    chk("bypassUser", 64'(userDrOut), 64'h0);
    chk("bypassBsr", 64'(bsrOut), bsrPat);

    // USER scan split by a pause, then an over-long scan that recirculates.
    loadIr(5'b00001);
    scanDr(64'hDEAD_BEEF, 32, 64'h0, 16);
    chk("pausedUser", 64'(userDrOut), 64'hDEAD_BEEF);
    scanDr(64'h5A_1234_5678, 40, 64'h78_DEAD_BEEF, 0);
    chk("longUser", 64'(userDrOut), 64'h5A12_3456);
    chk("queueDrained", 64'(expQ.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
